control_unit: RTL and testbench
===============================

# control_unit

Sequencing controller for the 8-bit RISC stored-program machine. It sits directly upstream of the ALU and datapath. A Moore/Mealy FSM fetches each instruction, decodes the opcode and register fields, and drives every register-load, bus-mux and memory-write strobe. Its outputs steer the operands presented to the ALU and capture the ALU result and zero flag.

## Interface
- WORD_WIDTH, 8, instruction width.
  - Opcode is instruction[WORD_WIDTH-1 -: 4].
  - src is instruction[3:2].
  - dest is instruction[1:0].
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, asynchronous, active-high; forces S_idle.
- instruction  in  WORD_WIDTH  current IR contents.
- zero  in  1  registered ALU zero flag (Reg_Z output).
- Load_R0, Load_R1, Load_R2, Load_R3  out  1 each  register-file load enables.
- Load_PC  out  1  load PC from Bus_2.
- Inc_PC  out  1  PC <= PC+1.
- Sel_Bus_1_Mux  out  3  Bus_1 source: 0=R0, 1=R1, 2=R2, 3=R3, 4=PC.
- Sel_Bus_2_Mux  out  2  Bus_2 source: 0=ALU_out, 1=Bus_1, 2=memory.
- Load_IR  out  1  IR <= Bus_2.
- Load_Add_R  out  1  address register <= Bus_2.
- Load_Reg_Y  out  1  ALU operand register Y <= Bus_2.
- Load_Reg_Z  out  1  zero-flag register <= ALU_Zflag.
- write  out  1  memory write strobe (data = Bus_1, address = Add_R).
- halted  out  1  high while in S_halt.

## Operation
- Opcodes, 4-bit:
  - NOP=0, ADD=1, SUB=2, AND=3, NOT=4, RD=5, WR=6, BR=7, BRZ=8.
  - 9–15 are illegal.
- Outputs are combinational from state, plus instruction/zero in S_dec.
- Any strobe or select not listed for a state is 0.
- States:
  - S_idle: no strobes. Next state S_fet1.
  - S_fet1: Sel1=4, Sel2=1, Load_Add_R. Next state S_fet2.
  - S_fet2: Sel2=2, Load_IR, Inc_PC. Next state S_dec.
  - S_dec, decoded by opcode:
    - NOP: no strobes. Next state S_fet1.
    - ADD/SUB/AND: Sel1=src, Sel2=1, Load_Reg_Y. Next state S_ex1.
    - NOT: Sel1=src, Sel2=0, Load_Reg_Z, Load_R[dest]. Next state S_fet1.
    - RD/WR/BR: Sel1=4, Sel2=1, Load_Add_R. Next state S_rd1, S_wr1 or S_br1 respectively.
    - BRZ with zero=1: Sel1=4, Sel2=1, Load_Add_R. Next state S_br1.
    - BRZ with zero=0: Inc_PC only (skips the address byte). Next state S_fet1.
    - Illegal opcode: no strobes. Next state S_halt.
  - S_ex1: Sel1=dest, Sel2=0, Load_Reg_Z, Load_R[dest]. Next state S_fet1.
    - ALU data_1=Bus_1 (dest) and data_2=Reg_Y (src), so SUB yields src−dest.
  - S_rd1: Sel2=2, Load_Add_R, Inc_PC. Next state S_rd2.
  - S_rd2: Sel2=2, Load_R[dest]. Next state S_fet1.
  - S_wr1: Sel2=2, Load_Add_R, Inc_PC. Next state S_wr2.
  - S_wr2: Sel1=src, write. Next state S_fet1.
  - S_br1: Sel2=2, Load_Add_R. Next state S_br2.
  - S_br2: Sel2=2, Load_PC. Next state S_fet1.
  - S_halt: no strobes, halted=1. Stays in S_halt until rst.
- At most one Load_R* is high in any cycle.
- Load_PC and Inc_PC are never both high.
- Unreachable state encodings go to S_halt on the next edge.

## Timing
- Reset:
  - On rst assertion, state=S_idle immediately, without waiting for clk.
  - All outputs are 0 while rst is high.
  - The first cycle after rst deasserts is S_idle; S_fet1 follows.
- Instruction latency, from S_fet1 entry to the next S_fet1:
  - NOP, NOT, BRZ not-taken: 3 cycles.
  - ADD/SUB/AND: 4 cycles.
  - RD, WR, BR, BRZ taken: 5 cycles.
- Sampling:
  - zero is sampled only in S_dec.
  - instruction is valid from the cycle after S_fet2 onward.
- Reset mid-instruction aborts the instruction immediately; no partial strobe may appear after the rst edge.
- A taken branch reaches S_fet1 with the new PC already loaded.

## Test plan
- Reset then idle fetch:
  - Stimulus: hold rst 2 cycles, release, IR=8'h00.
  - Required: states S_idle, fet1, fet2, dec, fet1 repeating.
  - Required: Load_Add_R in fet1, Load_IR+Inc_PC in fet2, no other strobes.
- ADD R2,R1:
  - Stimulus: IR=8'h19.
  - Required in S_dec: Sel1=2, Sel2=1, Load_Reg_Y=1.
  - Required in S_ex1: Sel1=1, Sel2=0, Load_Reg_Z=1, Load_R1=1, all other loads 0.
  - Required: the instruction takes 4 cycles.
- BRZ:
  - Stimulus A: IR=8'h80, zero=0.
  - Required A: Inc_PC in S_dec, back to S_fet1 after 3 cycles.
  - Stimulus B: zero=1.
  - Required B: S_br1 then S_br2, with Load_PC=1 and Sel2=2 in S_br2.
- RD and WR:
  - Stimulus: IR=8'h53, then IR=8'h68.
  - Required for RD: S_rd2 asserts Load_R3 with Sel2=2.
  - Required for WR: S_wr2 asserts write=1 with Sel1=2.
  - Required: each instruction takes 5 cycles.
- Illegal opcode:
  - Stimulus: IR=8'hF0.
  - Required: S_halt after S_dec, halted=1, all strobes 0 for 10+ cycles.
  - Required: only rst exits the halt.
- Async reset mid-instruction:
  - Stimulus: assert rst between clock edges while in S_rd1.
  - Required: outputs 0 within the same cycle, state S_idle, normal fetch after release.

Source files
------------

// File: rtl/control_unit_if.sv
// rtl/control_unit_if.sv - control_unit instruction/flag inputs and datapath strobe bundle
interface control_unit_if #(
    parameter int WORD_WIDTH = 8
);
    logic [WORD_WIDTH-1:0] instruction;
    logic                  zero;
    logic                  Load_R0;
    logic                  Load_R1;
    logic                  Load_R2;
    logic                  Load_R3;
    logic                  Load_PC;
    logic                  Inc_PC;
    logic [2:0]            Sel_Bus_1_Mux;
    logic [1:0]            Sel_Bus_2_Mux;
    logic                  Load_IR;
    logic                  Load_Add_R;
    logic                  Load_Reg_Y;
    logic                  Load_Reg_Z;
    logic                  write;
    logic                  halted;

    modport master (
        input  instruction, zero,
        output Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC,
               Sel_Bus_1_Mux, Sel_Bus_2_Mux, Load_IR, Load_Add_R,
               Load_Reg_Y, Load_Reg_Z, write, halted
    );

    modport slave (
        output instruction, zero,
        input  Load_R0, Load_R1, Load_R2, Load_R3, Load_PC, Inc_PC,
               Sel_Bus_1_Mux, Sel_Bus_2_Mux, Load_IR, Load_Add_R,
               Load_Reg_Y, Load_Reg_Z, write, halted
    );
endinterface

// File: rtl/control_unit.sv
// rtl/control_unit.sv - fetch/decode/execute sequencer for the 8-bit RISC machine
module control_unit #(
    parameter int WORD_WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    control_unit_if.master cu
);
    typedef enum logic [3:0] {
        S_idle = 4'd0,
        S_fet1 = 4'd1,
        S_fet2 = 4'd2,
        S_dec  = 4'd3,
        S_ex1  = 4'd4,
        S_rd1  = 4'd5,
        S_rd2  = 4'd6,
        S_wr1  = 4'd7,
        S_wr2  = 4'd8,
        S_br1  = 4'd9,
        S_br2  = 4'd10,
        S_halt = 4'd11
    } state_t;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_NOT = 4'd4;
    localparam logic [3:0] OP_RD  = 4'd5;
    localparam logic [3:0] OP_WR  = 4'd6;
    localparam logic [3:0] OP_BR  = 4'd7;
    localparam logic [3:0] OP_BRZ = 4'd8;

    localparam logic [2:0] SEL1_PC  = 3'd4;
    localparam logic [1:0] SEL2_ALU = 2'd0;
    localparam logic [1:0] SEL2_BUS = 2'd1;
    localparam logic [1:0] SEL2_MEM = 2'd2;

    state_t     state;
    state_t     state_next;
    logic [3:0] opcode;
    logic [1:0] src;
    logic [1:0] dest;
    logic [3:0] load_r;

    assign opcode = cu.instruction[WORD_WIDTH-1 -: 4];
    assign src    = cu.instruction[3:2];
    assign dest   = cu.instruction[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_idle;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = S_halt;
        case (state)
            S_idle: state_next = S_fet1;
            S_fet1: state_next = S_fet2;
            S_fet2: state_next = S_dec;
            S_dec: begin
                case (opcode)
                    OP_NOP:                 state_next = S_fet1;
                    OP_ADD, OP_SUB, OP_AND: state_next = S_ex1;
                    OP_NOT:                 state_next = S_fet1;
                    OP_RD:                  state_next = S_rd1;
                    OP_WR:                  state_next = S_wr1;
                    OP_BR:                  state_next = S_br1;
                    OP_BRZ:                 state_next = cu.zero ? S_br1 : S_fet1;
                    default:                state_next = S_halt;
                endcase
            end
            S_ex1:  state_next = S_fet1;
            S_rd1:  state_next = S_rd2;
            S_rd2:  state_next = S_fet1;
            S_wr1:  state_next = S_wr2;
            S_wr2:  state_next = S_fet1;
            S_br1:  state_next = S_br2;
            S_br2:  state_next = S_fet1;
            S_halt: state_next = S_halt;
            default: state_next = S_halt;
        endcase
    end

    // Register-file loads go through a one-hot vector so only dest can ever fire.
    always_comb begin
        load_r           = 4'b0000;
        cu.Load_PC       = 1'b0;
        cu.Inc_PC        = 1'b0;
        cu.Sel_Bus_1_Mux = 3'd0;
        cu.Sel_Bus_2_Mux = 2'd0;
        cu.Load_IR       = 1'b0;
        cu.Load_Add_R    = 1'b0;
        cu.Load_Reg_Y    = 1'b0;
        cu.Load_Reg_Z    = 1'b0;
        cu.write         = 1'b0;
        cu.halted        = 1'b0;
        case (state)
            S_fet1: begin
                cu.Sel_Bus_1_Mux = SEL1_PC;
                cu.Sel_Bus_2_Mux = SEL2_BUS;
                cu.Load_Add_R    = 1'b1;
            end
            S_fet2: begin
                cu.Sel_Bus_2_Mux = SEL2_MEM;
                cu.Load_IR       = 1'b1;
                cu.Inc_PC        = 1'b1;
            end
            S_dec: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND: begin
                        cu.Sel_Bus_1_Mux = {1'b0, src};
                        cu.Sel_Bus_2_Mux = SEL2_BUS;
                        cu.Load_Reg_Y    = 1'b1;
                    end
                    OP_NOT: begin
                        cu.Sel_Bus_1_Mux = {1'b0, src};
                        cu.Sel_Bus_2_Mux = SEL2_ALU;
                        cu.Load_Reg_Z    = 1'b1;
                        load_r[dest]     = 1'b1;
                    end
                    OP_RD, OP_WR, OP_BR: begin
                        cu.Sel_Bus_1_Mux = SEL1_PC;
                        cu.Sel_Bus_2_Mux = SEL2_BUS;
                        cu.Load_Add_R    = 1'b1;
                    end
                    OP_BRZ: begin
                        if (cu.zero) begin
                            cu.Sel_Bus_1_Mux = SEL1_PC;
                            cu.Sel_Bus_2_Mux = SEL2_BUS;
                            cu.Load_Add_R    = 1'b1;
                        end else begin
                            // Not taken: step PC over the branch-target byte.
                            cu.Inc_PC = 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            S_ex1: begin
                cu.Sel_Bus_1_Mux = {1'b0, dest};
                cu.Sel_Bus_2_Mux = SEL2_ALU;
                cu.Load_Reg_Z    = 1'b1;
                load_r[dest]     = 1'b1;
            end
            S_rd1, S_wr1: begin
                cu.Sel_Bus_2_Mux = SEL2_MEM;
                cu.Load_Add_R    = 1'b1;
                cu.Inc_PC        = 1'b1;
            end
            S_rd2: begin
                cu.Sel_Bus_2_Mux = SEL2_MEM;
                load_r[dest]     = 1'b1;
            end
            S_wr2: begin
                cu.Sel_Bus_1_Mux = {1'b0, src};
                cu.write         = 1'b1;
            end
            S_br1: begin
                cu.Sel_Bus_2_Mux = SEL2_MEM;
                cu.Load_Add_R    = 1'b1;
            end
            S_br2: begin
                cu.Sel_Bus_2_Mux = SEL2_MEM;
                cu.Load_PC       = 1'b1;
            end
            S_halt: begin
                cu.halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign cu.Load_R0 = load_r[0];
    assign cu.Load_R1 = load_r[1];
    assign cu.Load_R2 = load_r[2];
    assign cu.Load_R3 = load_r[3];
endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - scoreboard bench for control_unit strobe sequencing
module tb_control_unit;
    logic clk = 1'b0;
    logic rst;

    control_unit_if #(.WORD_WIDTH(8)) bus ();

    control_unit #(.WORD_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .cu  (bus.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] v;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // {R3,R2,R1,R0, Load_PC, Inc_PC, Sel1[3], Sel2[2], IR, Add_R, Reg_Y, Reg_Z, write, halted}
    function automatic logic [16:0] ev(input logic [3:0] lr, input logic pc, input logic inc,
                                       input logic [2:0] s1, input logic [1:0] s2,
                                       input logic ir, input logic ar, input logic y,
                                       input logic z, input logic w, input logic h);
        return {lr, pc, inc, s1, s2, ir, ar, y, z, w, h};
    endfunction

    function automatic logic [16:0] actual();
        return {bus.Load_R3, bus.Load_R2, bus.Load_R1, bus.Load_R0, bus.Load_PC, bus.Inc_PC,
                bus.Sel_Bus_1_Mux, bus.Sel_Bus_2_Mux, bus.Load_IR, bus.Load_Add_R,
                bus.Load_Reg_Y, bus.Load_Reg_Z, bus.write, bus.halted};
    endfunction

    task automatic check(input string name, input logic [16:0] want);
        logic [16:0] got;
        got = actual();
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %b required %b at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check(e.name, e.v);
        end
    end

    task automatic cyc(input string name, input logic [16:0] e);
        exp_t x;
        x.v = e;
        x.name = name;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    logic [16:0] NONE, FET1, FET2, ADDR_PC, MEM_AR_INC, BR1, BR2, HALT;

    task automatic fetch(input logic [7:0] ir);
        bus.instruction = ir;
        cyc("fet1", FET1);
        cyc("fet2", FET2);
    endtask

    initial begin
        NONE       = ev(4'b0000, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0);
        FET1       = ev(4'b0000, 0, 0, 3'd4, 2'd1, 0, 1, 0, 0, 0, 0);
        FET2       = ev(4'b0000, 0, 1, 3'd0, 2'd2, 1, 0, 0, 0, 0, 0);
        ADDR_PC    = ev(4'b0000, 0, 0, 3'd4, 2'd1, 0, 1, 0, 0, 0, 0);
        MEM_AR_INC = ev(4'b0000, 0, 1, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0);
        BR1        = ev(4'b0000, 0, 0, 3'd0, 2'd2, 0, 1, 0, 0, 0, 0);
        BR2        = ev(4'b0000, 1, 0, 3'd0, 2'd2, 0, 0, 0, 0, 0, 0);
        HALT       = ev(4'b0000, 0, 0, 3'd0, 2'd0, 0, 0, 0, 0, 0, 1);

        rst = 1'b1;
        bus.instruction = 8'h00;
        bus.zero = 1'b0;
        @(posedge clk);
        #1;
        cyc("rst_hold0", NONE);
        cyc("rst_hold1", NONE);
        rst = 1'b0;
        cyc("idle", NONE);

        // NOP loop: 3 cycles per instruction
        for (int i = 0; i < 2; i++) begin
            fetch(8'h00);
            cyc("nop_dec", NONE);
        end

        // ADD R2,R1: src=2, dest=1
        fetch(8'h19);
        cyc("add_dec", ev(4'b0000, 0, 0, 3'd2, 2'd1, 0, 0, 1, 0, 0, 0));
        cyc("add_ex1", ev(4'b0010, 0, 0, 3'd1, 2'd0, 0, 0, 0, 1, 0, 0));

        // SUB R3,R0: src=3, dest=0
        fetch(8'h2C);
        cyc("sub_dec", ev(4'b0000, 0, 0, 3'd3, 2'd1, 0, 0, 1, 0, 0, 0));
        cyc("sub_ex1", ev(4'b0001, 0, 0, 3'd0, 2'd0, 0, 0, 0, 1, 0, 0));

        // NOT R1 -> R3
        fetch(8'h47);
        cyc("not_dec", ev(4'b1000, 0, 0, 3'd1, 2'd0, 0, 0, 0, 1, 0, 0));

        // BRZ not taken
        bus.zero = 1'b0;
        fetch(8'h80);
        cyc("brz_nt_dec", ev(4'b0000, 0, 1, 3'd0, 2'd0, 0, 0, 0, 0, 0, 0));

        // BRZ taken
        bus.zero = 1'b1;
        fetch(8'h80);
        cyc("brz_t_dec", ADDR_PC);
        bus.zero = 1'b0;
        cyc("brz_t_br1", BR1);
        cyc("brz_t_br2", BR2);

        // RD -> R3
        fetch(8'h53);
        cyc("rd_dec", ADDR_PC);
        cyc("rd_rd1", MEM_AR_INC);
        cyc("rd_rd2", ev(4'b1000, 0, 0, 3'd0, 2'd2, 0, 0, 0, 0, 0, 0));

        // WR from R2
        fetch(8'h68);
        cyc("wr_dec", ADDR_PC);
        cyc("wr_wr1", MEM_AR_INC);
        cyc("wr_wr2", ev(4'b0000, 0, 0, 3'd2, 2'd0, 0, 0, 0, 0, 1, 0));

        // BR unconditional
        fetch(8'h70);
        cyc("br_dec", ADDR_PC);
        cyc("br_br1", BR1);
        cyc("br_br2", BR2);

        // Async reset asserted mid-cycle while in S_rd1
        fetch(8'h53);
        cyc("rd_dec2", ADDR_PC);
        begin
            exp_t x;
            x.v = MEM_AR_INC;
            x.name = "rd_rd1_pre_rst";
            exp_q.push_back(x);
        end
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_outputs", NONE);
        @(posedge clk);
        #1;
        cyc("async_rst_hold", NONE);
        rst = 1'b0;
        cyc("post_rst_idle", NONE);
        fetch(8'h00);
        cyc("post_rst_nop_dec", NONE);

        // Illegal opcode halts until reset
        fetch(8'hF0);
        cyc("ill_dec", NONE);
        bus.instruction = 8'h00;
        for (int i = 0; i < 12; i++) cyc("halt", HALT);
        rst = 1'b1;
        cyc("halt_rst", NONE);
        rst = 1'b0;
        cyc("halt_exit_idle", NONE);
        cyc("halt_exit_fet1", FET1);

        repeat (3) @(posedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
